// File: rtl/signed_adder_pkg.sv
// Shared op codes and overflow helpers for the signed add/sub pipeline.
// Saturation is selected in the top with SIGNED_ADDSUB_SAT_EN.
package signed_adder_pkg;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_ACC  = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   function automatic longint max_of(input int aw);
      return (64'sd1 <<< (aw - 1)) - 64'sd1;
   endfunction

   function automatic longint min_of(input int aw);
      return -max_of(aw) - 64'sd1;
   endfunction

   function automatic logic fits(input longint s, input int aw);
      return (s <= max_of(aw)) && (s >= min_of(aw));
   endfunction

   function automatic longint sat_clamp(input longint s, input int aw);
      if (s > max_of(aw)) return max_of(aw);
      if (s < min_of(aw)) return min_of(aw);
      return s;
   endfunction

endpackage

// File: rtl/signed_pipe_reg.sv
// One stall-able delay stage: valid, result and ovf.
// Data only loads with a valid beat so outputs hold across bubbles.
module signed_pipe_reg #(
   parameter int AW = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          in_valid,
   input  logic [AW-1:0] in_data,
   input  logic          in_ovf,
   output logic          out_valid,
   output logic [AW-1:0] out_data,
   output logic          out_ovf
);

   logic          valid_q, valid_d;
   logic [AW-1:0] data_q, data_d;
   logic          ovf_q, ovf_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ovf_d   = ovf_q;
      if (en) begin
         valid_d = in_valid;
         if (in_valid) begin
            data_d = in_data;
            ovf_d  = in_ovf;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_ovf   = ovf_q;

endmodule

// File: rtl/signed_addsub_pipe.sv
// Pipelined signed add/sub/accumulate with valid/ready and overflow flag.
// Define SIGNED_ADDSUB_SAT_EN to saturate the accumulator instead of wrapping.
module signed_addsub_pipe
   import signed_adder_pkg::*;
#(
   parameter int WL   = 16,
   parameter int AW   = WL + 4,
   parameter int PIPE = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    op,
   input  logic [WL-1:0] a,
   input  logic [WL-1:0] b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] result,
   output logic          ovf
);

   logic                 advance;
   logic                 v1_q, v1_d;
   logic                 o1_q, o1_d;
   logic [AW-1:0]        r1_q, r1_d;
   logic [AW-1:0]        acc_q, acc_d;
   logic signed [AW-1:0] xa, xb;
   logic signed [AW:0]   s;
   logic [AW-1:0]        acc_nxt;
   logic                 acc_ovf;

   logic [PIPE-1:0]          sv;
   logic [PIPE-1:0]          so;
   logic [PIPE-1:0][AW-1:0]  sr;

   assign out_valid = sv[PIPE-1];
   assign result    = sr[PIPE-1];
   assign ovf       = so[PIPE-1];
   assign advance   = out_ready || !out_valid;
   assign in_ready  = advance;

   // Accumulator sum is formed one bit wider so overflow is exact.
   always_comb begin
      xa      = {{(AW-WL){a[WL-1]}}, a};
      xb      = {{(AW-WL){b[WL-1]}}, b};
      s       = {acc_q[AW-1], acc_q} + {xa[AW-1], xa};
      acc_ovf = !fits(longint'(s), AW);
`ifdef SIGNED_ADDSUB_SAT_EN
      acc_nxt = AW'(sat_clamp(longint'(s), AW));
`else
      acc_nxt = s[AW-1:0];
`endif
   end

   always_comb begin
      v1_d  = v1_q;
      r1_d  = r1_q;
      o1_d  = o1_q;
      acc_d = acc_q;
      if (advance) begin
         v1_d = in_valid;
         if (in_valid) begin
            o1_d = 1'b0;
            unique case (op)
               OP_ADD: r1_d = xa + xb;
               OP_SUB: r1_d = xa - xb;
               OP_ACC: begin
                  r1_d  = acc_nxt;
                  o1_d  = acc_ovf;
                  acc_d = acc_nxt;
               end
               OP_LOAD: begin
                  r1_d  = xa;
                  acc_d = xa;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q  <= 1'b0;
         r1_q  <= '0;
         o1_q  <= 1'b0;
         acc_q <= '0;
      end else begin
         v1_q  <= v1_d;
         r1_q  <= r1_d;
         o1_q  <= o1_d;
         acc_q <= acc_d;
      end
   end

   assign sv[0] = v1_q;
   assign sr[0] = r1_q;
   assign so[0] = o1_q;

   for (genvar k = 1; k < PIPE; k++) begin : g_stg
      signed_pipe_reg #(.AW(AW)) u_stg (
         .clk       (clk),
         .rst       (rst),
         .en        (advance),
         .in_valid  (sv[k-1]),
         .in_data   (sr[k-1]),
         .in_ovf    (so[k-1]),
         .out_valid (sv[k]),
         .out_data  (sr[k]),
         .out_ovf   (so[k])
      );
   end

endmodule

// File: tb/tb_signed_addsub_pipe.sv
// Scoreboard bench for signed_addsub_pipe (WL=16, AW=20, PIPE=2).
// Directed cases then a random soak with random out_ready.
module tb_signed_addsub_pipe;

   localparam int WL   = 16;
   localparam int AW   = 20;
   localparam int PIPE = 2;
   localparam longint MAXV = (64'sd1 <<< (AW - 1)) - 64'sd1;
   localparam longint MINV = -MAXV - 64'sd1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    op = 2'b00;
   logic [WL-1:0] a = '0;
   logic [WL-1:0] b = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [AW-1:0] result;
   logic          ovf;

   signed_addsub_pipe #(.WL(WL), .AW(AW), .PIPE(PIPE)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint r;
      bit     o;
      int     c;
   } exp_t;

   int     errs = 0;
   int     checks = 0;
   int     cyc = 0;
   int     stall_seen = 0;
   bit     lat_chk = 0;
   bit     rnd_or = 0;
   exp_t   sb[$];
   longint log_r[$];
   bit     log_o[$];
   int     log_c[$];
   longint acc_m = 0;
   exp_t   e_m;
   longint sa, sbv, ss;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint wrapv(input longint s);
      longint w;
      w = s & ((64'sd1 <<< AW) - 64'sd1);
      if (w > MAXV) w = w - (64'sd1 <<< AW);
      return w;
   endfunction

   // Scoreboard: pop on output transfer, push the model result on input transfer.
   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready) begin
         if (sb.size() == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            e_m = sb.pop_front();
            chk("result", longint'($signed(result)), e_m.r);
            chk("ovf", longint'(ovf), longint'(e_m.o));
            if (lat_chk) chk("latency", cyc - e_m.c, PIPE);
         end
         log_r.push_back(longint'($signed(result)));
         log_o.push_back(ovf);
         log_c.push_back(cyc);
      end
      if (rst) begin
         sb.delete();
         acc_m = 0;
      end else begin
         if (out_valid === 1'b1 && !out_ready) begin
            stall_seen++;
            chk("stall_in_ready", longint'(in_ready), 0);
         end
         if (in_valid && in_ready) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            e_m.o = 1'b0;
            e_m.c = cyc;
            case (op)
               2'b00: e_m.r = sa + sbv;
               2'b01: e_m.r = sa - sbv;
               2'b11: begin
                  acc_m = sa;
                  e_m.r = sa;
               end
               default: begin
                  ss = acc_m + sa;
                  if (ss > MAXV || ss < MINV) begin
                     e_m.o = 1'b1;
`ifdef SIGNED_ADDSUB_SAT_EN
                     ss = (ss > MAXV) ? MAXV : MINV;
`else
                     ss = wrapv(ss);
`endif
                  end
                  acc_m = ss;
                  e_m.r = ss;
               end
            endcase
            sb.push_back(e_m);
         end
      end
   end

   always @(posedge clk) begin
      if (rnd_or) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input logic [1:0] o, input int av, input int bv);
      int n;
      bit took;
      n = 0;
      took = 0;
      in_valid = 1'b1;
      op = o;
      a = 16'(av);
      b = 16'(bv);
      while (!took && n < 200) begin
         @(negedge clk);
         took = in_ready && !rst;
         @(posedge clk);
         #1;
         n++;
      end
      if (!took) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("drain_empty", sb.size(), 0);
   endtask

   initial begin
      int n0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_result", longint'($signed(result)), 0);
      chk("rst_ovf", longint'(ovf), 0);
      chk("rst_in_ready", longint'(in_ready), 1);
      @(posedge clk);
      #1;
      lat_chk = 1;

      send(2'b00, 32767, 1);
      send(2'b01, -32768, 1);
      drain();

      send(2'b11, 100, 0);
      repeat (3) send(2'b10, 50, 0);
      send(2'b00, 1, 2);
      send(2'b10, 50, 0);
      drain();
      send(2'b11, 200, 0);
      send(2'b10, 50, 0);
      drain();

      // acc=250; two ADDs in flight, consumer idle, then a reset pulse
      send(2'b00, 5, 6);
      send(2'b00, 7, 8);
      rst = 1'b1;
      out_ready = 1'b0;
      in_valid = 1'b1;
      op = 2'b10;
      a = 16'(1000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("flush_out_valid", longint'(out_valid), 0);
      chk("flush_result", longint'($signed(result)), 0);
      chk("post_rst_count", log_r.size(), 10);
      @(posedge clk);
      #1;
      send(2'b10, 5, 0);
      drain();

      send(2'b11, 32767, 0);
      repeat (16) send(2'b10, 32767, 0);
      drain();

      chk("log_len", log_r.size(), 28);
      chk("add_max", log_r[0], 32768);
      chk("add_ovf", longint'(log_o[0]), 0);
      chk("sub_min", log_r[1], -32769);
      chk("load_100", log_r[2], 100);
      chk("acc_150", log_r[3], 150);
      chk("acc_200", log_r[4], 200);
      chk("acc_250", log_r[5], 250);
      chk("acc_consec", log_c[5] - log_c[2], 3);
      chk("interleave_add", log_r[6], 3);
      chk("interleave_acc", log_r[7], 300);
      chk("acc_after_rst", log_r[10], 5);
      chk("acc_pre_ovf", log_r[26], 524272);
      chk("acc_pre_ovf_flag", longint'(log_o[26]), 0);
`ifdef SIGNED_ADDSUB_SAT_EN
      chk("acc_ovf_val", log_r[27], 524287);
`else
      chk("acc_ovf_val", log_r[27], -491537);
`endif
      chk("acc_ovf_flag", longint'(log_o[27]), 1);

      lat_chk = 0;
      n0 = log_r.size();
      stall_seen = 0;
      fork
         begin
            for (int k = 0; k < 8; k++) send(2'b00, k * 1000, k);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_count", log_r.size() - n0, 8);
      chk("stall_seen", longint'(stall_seen > 0), 1);
      for (int k = 0; k < 8; k++) chk("stall_order", log_r[n0 + k], k * 1001);

      rnd_or = 1;
      for (int t = 0; t < 10000; t++) begin
         int av;
         if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         if ($urandom_range(0, 3) == 0)
            av = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
         else
            av = $urandom_range(0, 65535) - 32768;
         send(2'($urandom_range(0, 3)), av, $urandom_range(0, 65535) - 32768);
      end
      in_valid = 1'b0;
      rnd_or = 0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
